// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor with valid/ready word handshakes
module serial_subtractor_fs (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~a_i & bin_i) | (b_i & bin_i);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,      state_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic [WIDTH-1:0] res_q,        res_d;
    logic             borrow_q,     borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             in_ready_q,   in_ready_d;
    logic             out_valid_q,  out_valid_d;

    logic fs_d;
    logic fs_bout;

    serial_subtractor_fs u_fs (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (borrow_q),
        .d_o    (fs_d),
        .bout_o (fs_bout)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = minuend;
                    b_d      = subtrahend;
                    borrow_d = borrow_in;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Result fills from the MSB end so after WIDTH shifts bit 0 is the first computed bit.
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = {fs_d, res_q[WIDTH-1:1]};
                borrow_d = fs_bout;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    borrow_out_d = fs_bout;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign difference = res_q;
    assign borrow_out = borrow_out_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH 8 and 13
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic iv8 = 1'b0, ir8, ov8, or8 = 1'b1, bi8 = 1'b0, bo8;
    logic [7:0] a8 = '0, b8 = '0, d8;
    logic iv13 = 1'b0, ir13, ov13, or13 = 1'b1, bi13 = 1'b0, bo13;
    logic [12:0] a13 = '0, b13 = '0, d13;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .minuend(a8), .subtrahend(b8), .borrow_in(bi8),
        .out_valid(ov8), .out_ready(or8), .difference(d8), .borrow_out(bo8)
    );
    serial_subtractor #(.WIDTH(13)) u13 (
        .clk(clk), .rst(rst), .in_valid(iv13), .in_ready(ir13),
        .minuend(a13), .subtrahend(b13), .borrow_in(bi13),
        .out_valid(ov13), .out_ready(or13), .difference(d13), .borrow_out(bo13)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0]  q8[$];
    logic [13:0] q13[$];
    logic rnd8 = 1'b0, rnd13 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {8'd0, bin};
    endfunction

    function automatic logic [13:0] model13(input logic [12:0] a, input logic [12:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {13'd0, bin};
    endfunction

    // Scoreboard monitors: pop on every output handshake
    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) begin
                chk("unexpected_out8", 32'(d8), 32'hDEAD);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                chk("diff8", 32'(d8), 32'(e[7:0]));
                chk("bout8", 32'(bo8), 32'(e[8]));
            end
        end
        if (!rst && ov13 && or13) begin
            if (q13.size() == 0) begin
                chk("unexpected_out13", 32'(d13), 32'hDEAD);
            end else begin
                logic [13:0] e;
                e = q13.pop_front();
                chk("diff13", 32'(d13), 32'(e[12:0]));
                chk("bout13", 32'(bo13), 32'(e[13]));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd8)  or8  = 1'($urandom_range(0, 1));
            if (rnd13) or13 = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic [8:0] exp);
        bit got = 0;
        a8 = a; b8 = b; bi8 = bin; iv8 = 1'b1;
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk);
            if (ir8) got = 1;
        end
        if (!got) chk("accept_timeout8", 32'd0, 32'd1);
        @(posedge clk);
        q8.push_back(exp);
        #1 iv8 = 1'b0;
    endtask

    task automatic issue13(input logic [12:0] a, input logic [12:0] b, input logic bin);
        bit got = 0;
        a13 = a; b13 = b; bi13 = bin; iv13 = 1'b1;
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk);
            if (ir13) got = 1;
        end
        if (!got) chk("accept_timeout13", 32'd0, 32'd1);
        @(posedge clk);
        q13.push_back(model13(a, b, bin));
        #1 iv13 = 1'b0;
    endtask

    task automatic drain8();
        for (int n = 0; n < 2000 && q8.size() != 0; n++) @(posedge clk);
        chk("drain8", 32'(q8.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain13();
        for (int n = 0; n < 2000 && q13.size() != 0; n++) @(posedge clk);
        chk("drain13", 32'(q13.size()), 32'd0);
    endtask

    task automatic wait_ov8(output int lat);
        lat = 1;
        while (!ov8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct { logic [7:0] a; logic [7:0] b; logic bin; logic [8:0] exp; } vec_t;
    vec_t vecs[5];

    initial begin
        int lat;
        vecs[0] = '{8'd5,  8'd9,  1'b0, {1'b1, 8'hFC}};
        vecs[1] = '{8'd0,  8'd0,  1'b1, {1'b1, 8'hFF}};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF}};
        vecs[3] = '{8'hFF, 8'h00, 1'b0, {1'b0, 8'hFF}};
        vecs[4] = '{8'h80, 8'h01, 1'b0, {1'b0, 8'h7F}};

        @(negedge clk);
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_diff", 32'(d8), 32'd0);
        chk("rst_bout", 32'(bo8), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic op with latency and in_ready return
        issue8(8'd100, 8'd37, 1'b0, {1'b0, 8'd63});
        wait_ov8(lat);
        chk("latency", 32'(lat), 32'd9);
        @(posedge clk); #1;
        chk("in_ready_after_hs", 32'(ir8), 32'd1);
        chk("out_valid_after_hs", 32'(ov8), 32'd0);

        foreach (vecs[i]) begin
            issue8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp);
            drain8();
        end

        // Backpressure: result held, new op blocked until after handshake
        or8 = 1'b0;
        issue8(8'd200, 8'd50, 1'b0, {1'b0, 8'h96});
        wait_ov8(lat);
        a8 = 8'h11; b8 = 8'h22; bi8 = 1'b0; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(ov8), 32'd1);
            chk("bp_diff", 32'(d8), 32'h96);
            chk("bp_bout", 32'(bo8), 32'd0);
            chk("bp_in_ready", 32'(ir8), 32'd0);
        end
        @(posedge clk); #1;
        or8 = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_hs", 32'(ir8), 32'd0);
        @(posedge clk); #1;
        chk("bp_in_ready_post", 32'(ir8), 32'd1);
        chk("bp_out_valid_post", 32'(ov8), 32'd0);
        @(posedge clk);
        q8.push_back({1'b1, 8'hEF});
        #1 iv8 = 1'b0;
        chk("bp_accepted", 32'(ir8), 32'd0);
        drain8();

        // Asynchronous reset mid-RUN
        issue8(8'hF0, 8'h0F, 1'b0, {1'b0, 8'hE1});
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(ir8), 32'd1);
        chk("mid_rst_out_valid", 32'(ov8), 32'd0);
        chk("mid_rst_diff", 32'(d8), 32'd0);
        chk("mid_rst_bout", 32'(bo8), 32'd0);
        q8.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        issue8(8'h10, 8'h01, 1'b0, {1'b0, 8'h0F});
        drain8();

        // 16-bit chain: 0x1234 - 0x1056 = 0x01DE
        issue8(8'h34, 8'h56, 1'b0, {1'b1, 8'hDE});
        issue8(8'h12, 8'h10, 1'b1, {1'b0, 8'h01});
        drain8();

        fork
            begin
                rnd8 = 1'b1;
                for (int i = 0; i < 1000; i++) begin
                    logic [7:0] ra, rb;
                    logic rc;
                    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    issue8(ra, rb, rc, model8(ra, rb, rc));
                end
                rnd8 = 1'b0;
                #2 or8 = 1'b1;
                drain8();
            end
            begin
                rnd13 = 1'b1;
                for (int i = 0; i < 1000; i++) begin
                    logic [12:0] ra, rb;
                    logic rc;
                    ra = 13'($urandom); rb = 13'($urandom); rc = 1'($urandom);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    issue13(ra, rb, rc);
                end
                rnd13 = 1'b0;
                #2 or13 = 1'b1;
                drain13();
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
